// File: rtl/alu_pkg.sv
// Shared ALU/shift-unit definitions: datapath constants and the shift sequencer state type.
package alu_pkg;

  localparam int WIDTH = 64;
  localparam int SHW   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_e;

endpackage

// File: rtl/lrs64_seq_lrs64.sv
// Single-place 64-bit logical right shifter: moves every bit down by one and fills bit 63 with 0.
module lrs64 (
  input  logic [63:0] din,
  output logic [63:0] dout
);

  assign dout = {1'b0, din[63:1]};

endmodule

// File: rtl/lrs64_seq.sv
// Multi-cycle right shifter: applies lrs64 once per clock until the captured shift amount is used up,
// optionally holding bit 63 to turn the logical shift into an arithmetic one.
module lrs64_seq #(
  parameter int WIDTH = 64,
  parameter int SHW   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  import alu_pkg::*;

  // The datapath is built around the fixed 64-bit lrs64 cell.
  if (WIDTH != alu_pkg::WIDTH || SHW != alu_pkg::SHW) begin : g_cfg_err
    $error("lrs64_seq supports only WIDTH=64, SHW=6");
  end

  shift_state_e     state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh_out;
  logic [WIDTH-1:0] sh_next;
  logic [SHW-1:0]   cnt;
  logic             mode;

  lrs64 u_lrs64 (
    .din  (acc),
    .dout (sh_out)
  );

  // Arithmetic mode keeps re-injecting the original sign bit at the top.
  assign sh_next = {(mode ? acc[WIDTH-1] : sh_out[WIDTH-1]), sh_out[WIDTH-2:0]};

  assign result = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            acc  <= num;
            cnt  <= shamt;
            mode <= arith;
            if (shamt != '0) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          acc <= sh_next;
          cnt <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lrs64_seq.sv
// Self-checking bench for lrs64_seq: directed cases with literal results plus randomized operations
// compared every cycle against an operation-level reference model.
module tb_lrs64_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] num;
  logic [5:0]  shamt;
  logic        arith;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 0;

  lrs64_seq #(.WIDTH(64), .SHW(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .num    (num),
    .shamt  (shamt),
    .arith  (arith),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference shift expressed with the language's own shift operators.
  function automatic logic [63:0] refShift(input logic [63:0] x, input int k, input logic a);
    logic signed [63:0] sx;
    sx = $signed(x);
    if (a) return 64'(sx >>> k);
    return x >> k;
  endfunction

  // Operation-level model: which operation is live, how many shifts it has had, and whether
  // its done cycle is still current.
  logic        mValid, mFresh, mArith;
  logic [63:0] mNum;
  int          mN, mK;

  always @(posedge clk) begin
    if (rst) begin
      mValid = 0; mFresh = 0; mArith = 0; mNum = '0; mN = 0; mK = 0;
    end else if ((!mValid || mK == mN) && start) begin
      mValid = 1; mFresh = 1; mNum = num; mN = int'(shamt); mArith = arith; mK = 0;
    end else if (mValid && mK < mN) begin
      mK = mK + 1;
    end else begin
      mFresh = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_busy", 64'(busy), 64'(mValid && mK < mN));
      checkOutput("model_done", 64'(done), 64'(mValid && mK == mN && mFresh));
      checkOutput("model_result", result, mValid ? refShift(mNum, mK, mArith) : 64'h0);
    end
  end

  // Present one start request at a falling edge; returns at the falling edge after acceptance.
  task automatic applyStimulus(input logic [63:0] n, input logic [5:0] s, input logic a);
    num = n; shamt = s; arith = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run one operation, optionally pulsing start with junk operands at busy cycle pokeAt.
  task automatic runOp(input logic [63:0] n, input logic [5:0] s, input logic a, input int pokeAt,
                       output int busyCycles, output bit gotDone);
    applyStimulus(n, s, a);
    busyCycles = 0;
    gotDone = 0;
    for (int i = 0; i < 200 && !gotDone; i++) begin
      if (done) begin
        gotDone = 1;
      end else begin
        if (busy) busyCycles++;
        start = (busyCycles == pokeAt);
        if (start) begin
          num = {$urandom, $urandom};
          shamt = 6'($urandom_range(1, 63));
          arith = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  int bc;
  bit gd;
  int sawDone;

  initial begin
    rst = 1'b1; start = 1'b1; num = 64'hDEAD_BEEF_0000_0001; shamt = 6'd5; arith = 1'b0;
    @(negedge clk);
    checkEn = 1;
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'h0);
    checkOutput("reset_done", 64'(done), 64'h0);
    checkOutput("reset_result", result, 64'h0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("after_reset_busy", 64'(busy), 64'h0);

    runOp(64'hF000_0000_0000_00F0, 6'd4, 1'b0, -1, bc, gd);
    checkOutput("logic4_done", 64'(gd), 64'h1);
    checkOutput("logic4_busycycles", 64'(bc), 64'd4);
    checkOutput("logic4_result", result, 64'h0F00_0000_0000_000F);
    @(negedge clk);

    runOp(64'h8000_0000_0000_0000, 6'd63, 1'b1, -1, bc, gd);
    checkOutput("arith63_busycycles", 64'(bc), 64'd63);
    checkOutput("arith63_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    runOp(64'h8000_0000_0000_0000, 6'd63, 1'b0, -1, bc, gd);
    checkOutput("logic63_result", result, 64'h1);
    @(negedge clk);

    runOp(64'h1234, 6'd0, 1'b0, -1, bc, gd);
    checkOutput("zero_done", 64'(gd), 64'h1);
    checkOutput("zero_busycycles", 64'(bc), 64'd0);
    checkOutput("zero_result", result, 64'h1234);
    runOp(64'h100, 6'd8, 1'b0, -1, bc, gd);
    checkOutput("b2b_busycycles", 64'(bc), 64'd8);
    checkOutput("b2b_result", result, 64'h1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle_hold_result", result, 64'h1);
    checkOutput("idle_done_low", 64'(done), 64'h0);

    runOp(64'hFFFF_0000_0000_0000, 6'd10, 1'b0, 3, bc, gd);
    checkOutput("poke_busycycles", 64'(bc), 64'd10);
    checkOutput("poke_result", result, 64'h003F_FFC0_0000_0000);
    @(negedge clk);

    applyStimulus(64'hFFFF_FFFF_0000_0000, 6'd10, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_busy", 64'(busy), 64'h0);
    checkOutput("midreset_done", 64'(done), 64'h0);
    checkOutput("midreset_result", result, 64'h0);
    sawDone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) sawDone++;
    end
    checkOutput("midreset_no_done", 64'(sawDone), 64'h0);

    for (int t = 0; t < 40; t++) begin
      logic [63:0] rn;
      logic [5:0]  rs;
      logic        ra;
      rn = {$urandom, $urandom};
      rs = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      ra = 1'($urandom);
      runOp(rn, rs, ra, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : -1, bc, gd);
      checkOutput("rand_done", 64'(gd), 64'h1);
      checkOutput("rand_busycycles", 64'(bc), 64'(rs));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    checkEn = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/lrs64_seq.md
Name: lrs64_seq

Overview:
- Multi-cycle shift sequencer built around the single-bit 64-bit logical right shifter (lrs64).
- Accepts an operand and a 6-bit shift amount, then applies lrs64 once per clock until the amount is exhausted.
- Optional arithmetic mode restores sign fill.
- Used by the ALU/shift unit wherever an N-bit right shift is needed without a 64x6 barrel shifter; area is traded for latency.

Parameters:
- WIDTH, 64, datapath width. Fixed to 64 because lrs64 is 64-bit; any other value is a configuration error.
- SHW, 6, shift-amount width; log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only when the block is ready (IDLE or DONE state).
- num  input  64  operand; captured on an accepted start.
- shamt  input  6  shift amount 0..63; captured on an accepted start.
- arith  input  1  1 = arithmetic (sign-fill) shift, 0 = logical (zero-fill); captured on an accepted start.
- busy  output  1  high while shifting (SHIFT state).
- done  output  1  one-cycle pulse: result is valid.
- result  output  64  shifted value; registered; holds until the next accepted start.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state to IDLE, busy 0, done 0, result 0, internal count 0.
  - Reset takes priority over start.
  - Reset mid-operation aborts the shift; no done pulse is produced.
- States: IDLE, SHIFT, DONE. Encoding is local to the block.
- IDLE:
  - start=1 with shamt!=0: acc <= num, cnt <= shamt, mode <= arith; go to SHIFT.
  - start=1 with shamt==0: acc <= num; go directly to DONE.
  - start=0: stay in IDLE.
- SHIFT (busy=1):
  - Every edge: acc <= lrs64(acc), with bit 63 forced to the old acc[63] when mode=1; cnt <= cnt-1.
  - When cnt==1 at an edge, that is the final shift; go to DONE.
  - start is ignored in SHIFT; num, shamt and arith may change freely.
- DONE (done=1, exactly one cycle):
  - start=1: accepted with the same rules as IDLE, which allows back-to-back operation.
  - start=0: go to IDLE.
- Latency:
  - Start accepted at edge E, shamt=N>=1: busy high for N cycles, done high in the cycle after edge E+N.
  - shamt=0: done high in the cycle after edge E, with no busy cycles.
- result mirrors acc. It is guaranteed only while done=1 or in IDLE after done; intermediate values are visible during SHIFT.
- Arithmetic rule: a logical shift fills with 0; an arithmetic shift replicates the original bit 63. A full 63-place arithmetic shift yields all-0s or all-1s.
- The count never wraps: cnt is only decremented in SHIFT, and the exit condition is cnt==1.

Decomposition:
- Shared package (alu_pkg): shift state enum (IDLE/SHIFT/DONE) and constants WIDTH=64, SHW=6.
- One sub-module instance: lrs64 (existing), fed by acc. Its bit 63 output is overridden by a mux in this block for arithmetic mode.
- Counter, FSM and acc register live in lrs64_seq itself.

Test Plan:
- Reset check: rst held 2 cycles with start=1 -> busy=0, done=0, result=0; no operation starts.
- Logical shift: num=64'hF000_0000_0000_00F0, shamt=4, arith=0 -> busy high 4 cycles, done in cycle 5, result=64'h0F00_0000_0000_000F.
- Arithmetic shift: num=64'h8000_0000_0000_0000, shamt=63, arith=1 -> done after 63 busy cycles, result=64'hFFFF_FFFF_FFFF_FFFF. Same operands with arith=0 -> result=64'h1.
- Zero shift and back-to-back:
  - shamt=0, num=64'h1234 -> done in the cycle after start, result=64'h1234, busy never high.
  - start held high in DONE with num=64'h100, shamt=8 -> new operation accepted immediately; done 9 cycles later, result=64'h1.
- Start while busy: start pulsed mid-SHIFT with different num/shamt -> ignored; the original result completes at the original cycle count.
- Reset mid-operation: rst asserted 3 cycles into shamt=10 -> next cycle busy=0, done=0, result=0; no done pulse is ever produced for that operation.
